// File: rtl/pp_wr_ctrl_if.sv
// pp_wr_ctrl_if: bundles the signals of the path-header write controller.
// Groups the beat stream (pp_*), the chunk RAM write port (ram_*) and the
// reader handshake (rd_ptr, chunk_*), plus the sticky ovf_err flag.
// The master modport is the environment side; the slave modport is the controller side.
interface pp_wr_ctrl_if #(
  parameter int DATA_NBITS  = 128,
  parameter int DEPTH_NBITS = 4
);
  logic                   pp_valid;
  logic                   pp_sop;
  logic                   pp_eop;
  logic [1:0]             pp_id;
  logic [DATA_NBITS-1:0]  pp_data;
  logic                   pp_ready;
  logic                   ram_wr;
  logic [DEPTH_NBITS:0]   ram_waddr;
  logic [DATA_NBITS-1:0]  ram_wdata;
  logic                   rd_ptr;
  logic                   chunk_valid;
  logic [DEPTH_NBITS:0]   chunk_len;
  logic                   chunk_done;
  logic                   ovf_err;
  modport master (
    output pp_valid, pp_sop, pp_eop, pp_id, pp_data, chunk_done,
    input  pp_ready, ram_wr, ram_waddr, ram_wdata, rd_ptr, chunk_valid, chunk_len, ovf_err
  );
  modport slave (
    input  pp_valid, pp_sop, pp_eop, pp_id, pp_data, chunk_done,
    output pp_ready, ram_wr, ram_waddr, ram_wdata, rd_ptr, chunk_valid, chunk_len, ovf_err
  );
endinterface

// File: rtl/pp_wr_ctrl.sv
// pp_wr_ctrl: writes one parser's path-header beats into a ping-pong chunk RAM.
// Ports: clk, rstn (async active-low), bus (pp_wr_ctrl_if.slave):
//   in  pp_valid/pp_sop/pp_eop/pp_id/pp_data, chunk_done
//   out pp_ready, ram_wr/ram_waddr/ram_wdata, rd_ptr, chunk_valid, chunk_len, ovf_err
module pp_wr_ctrl #(
  parameter int PP_ID       = 0,
  parameter int DATA_NBITS  = 128,
  parameter int DEPTH_NBITS = 4
) (
  input logic         clk,
  input logic         rstn,
  pp_wr_ctrl_if.slave bus
);
  localparam int AW = DEPTH_NBITS + 1;
  localparam logic [AW-1:0] LMAX = AW'(1 << DEPTH_NBITS);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t                  state;
  logic                    wr_ptr, rd_ptr, ready, wr, cv, ovf;
  logic [1:0]              buf_full, full_nxt;
  logic [1:0][AW-1:0]      len;
  logic [AW-1:0]           beat_cnt, waddr, clen, fill_len;
  logic [DATA_NBITS-1:0]   wdata;
  logic [DEPTH_NBITS-1:0]  wr_idx;
  logic                    acc, fire, start, adv, ovf_hit, fill, wr_en, wr_nxt, rd_nxt;
  assign acc = bus.pp_valid & ready & (bus.pp_id == 2'(PP_ID));
  // chunk_done only counts while the reader actually sees a full buffer
  assign fire = bus.chunk_done & cv;
  // sop starts or restarts a chunk at index 0; sop inside an overflowed chunk is just dropped
  assign start = acc & bus.pp_sop & (state != DROP);
  assign adv = acc & ~bus.pp_sop & (state == WRITE) & (beat_cnt != LMAX);
  assign ovf_hit = acc & ~bus.pp_sop & (state == WRITE) & (beat_cnt == LMAX);
  // eop closes the chunk from any in-chunk state; in IDLE only a sop+eop beat forms a chunk
  assign fill = acc & bus.pp_eop & (start | (state != IDLE));
  assign wr_en = start | adv;
  assign wr_idx = start ? '0 : beat_cnt[DEPTH_NBITS-1:0];
  assign fill_len = start ? AW'(1) : adv ? beat_cnt + AW'(1) : LMAX;
  assign wr_nxt = wr_ptr ^ fill;
  assign rd_nxt = rd_ptr ^ fire;
  assign full_nxt = (buf_full | (fill ? 2'b01 << wr_ptr : 2'b00)) & ~(fire ? 2'b01 << rd_ptr : 2'b00);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      beat_cnt <= '0;
      len <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      buf_full <= 2'b00;
      ready <= 1'b1;
      cv <= 1'b0;
      clen <= '0;
      ovf <= 1'b0;
      wr <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= fill ? IDLE : start ? WRITE : ovf_hit ? DROP : state;
      if (start) beat_cnt <= AW'(1);
      else if (adv) beat_cnt <= beat_cnt + AW'(1);
      if (fill) len[wr_ptr] <= fill_len;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      buf_full <= full_nxt;
      ready <= ~full_nxt[wr_nxt];
      // a consumed chunk always shows one idle cycle before the other buffer is offered
      cv <= ~fire & full_nxt[rd_nxt];
      clen <= (fill & (wr_ptr == rd_nxt)) ? fill_len : len[rd_nxt];
      ovf <= ovf | ovf_hit;
      wr <= wr_en;
      if (wr_en) begin
        waddr <= {wr_ptr, wr_idx};
        wdata <= bus.pp_data;
      end
    end
  end
  assign bus.pp_ready = ready;
  assign bus.ram_wr = wr;
  assign bus.ram_waddr = waddr;
  assign bus.ram_wdata = wdata;
  assign bus.rd_ptr = rd_ptr;
  assign bus.chunk_valid = cv;
  assign bus.chunk_len = clen;
  assign bus.ovf_err = ovf;
endmodule

// File: tb/tb_pp_wr_ctrl.sv
// tb_pp_wr_ctrl: directed and random beat streams checked against a chunk-level model.
module tb_pp_wr_ctrl;
  localparam int DW = 128;
  localparam int DN = 4;
  localparam int NB = 1 << DN;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  pp_wr_ctrl_if #(.DATA_NBITS(DW), .DEPTH_NBITS(DN)) bus ();
  pp_wr_ctrl #(.PP_ID(0), .DATA_NBITS(DW), .DEPTH_NBITS(DN)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );
  bit m_full[2];
  int m_len[2];
  bit m_wr, m_rd, m_ready, m_cv, m_ovf, m_wren, in_chunk, ovfd;
  int m_clen, m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] cur[$];
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic void model_reset();
    m_full[0] = 0; m_full[1] = 0; m_len[0] = 0; m_len[1] = 0;
    m_wr = 0; m_rd = 0; m_ready = 1; m_cv = 0; m_ovf = 0; m_wren = 0;
    in_chunk = 0; ovfd = 0; m_clen = 0; m_addr = 0; m_wdata = '0;
    cur.delete();
  endfunction
  function automatic void model_edge(bit v, bit s, bit e, logic [1:0] id, logic [DW-1:0] d, bit done);
    bit acc, fire;
    acc = v && m_ready && id == 2'd0;
    fire = done && m_cv;
    m_wren = 0;
    if (acc) begin
      if (s && !(in_chunk && ovfd)) begin
        cur.delete();
        in_chunk = 1;
        ovfd = 0;
      end
      if (in_chunk) begin
        if (!ovfd && cur.size() < NB) begin
          m_wren = 1;
          m_addr = int'(m_wr) * NB + cur.size();
          m_wdata = d;
          cur.push_back(d);
        end else begin
          m_ovf = 1;
          ovfd = 1;
        end
        if (e) begin
          m_full[m_wr] = 1;
          m_len[m_wr] = cur.size();
          m_wr = !m_wr;
          in_chunk = 0;
        end
      end
    end
    if (fire) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
    m_ready = !m_full[m_wr];
    m_cv = !fire && m_full[m_rd];
    m_clen = m_len[m_rd];
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("pp_ready", bus.pp_ready, m_ready);
    chk("ram_wr", bus.ram_wr, m_wren);
    chk("ram_waddr", bus.ram_waddr, m_addr);
    chk("ram_wdata", bus.ram_wdata, m_wdata);
    chk("rd_ptr", bus.rd_ptr, m_rd);
    chk("chunk_valid", bus.chunk_valid, m_cv);
    chk("chunk_len", bus.chunk_len, m_clen);
    chk("ovf_err", bus.ovf_err, m_ovf);
  endtask
  task automatic step(input bit v, input bit s, input bit e, input logic [1:0] id, input bit done);
    logic [DW-1:0] d;
    d = rnd();
    bus.pp_valid = v; bus.pp_sop = s; bus.pp_eop = e; bus.pp_id = id;
    bus.pp_data = d; bus.chunk_done = done;
    @(posedge clk);
    model_edge(v, s, e, id, d, done);
    #1;
    check_all();
  endtask
  task automatic idle(input bit done);
    step(0, 0, 0, 2'd0, done);
  endtask
  task automatic header(input int n);
    for (int k = 0; k < n; k++) step(1, k == 0, k == n - 1, 2'd0, 0);
  endtask
  task automatic do_reset();
    bus.pp_valid = 0; bus.pp_sop = 0; bus.pp_eop = 0; bus.pp_id = 0;
    bus.pp_data = '0; bus.chunk_done = 0;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask
  initial begin
    #2 do_reset();
    idle(0);
    header(3);
    chk("three_beat_len", bus.chunk_len, 3);
    chk("three_beat_valid", bus.chunk_valid, 1);
    idle(1);
    chk("done_rd_ptr", bus.rd_ptr, 1);
    idle(0);
    header(2);
    header(2);
    chk("both_full_ready", bus.pp_ready, 0);
    repeat (3) step(1, 1, 0, 2'd0, 0);
    step(1, 0, 1, 2'd0, 0);
    idle(1);
    chk("freed_ready", bus.pp_ready, 1);
    idle(0);
    chk("second_len", bus.chunk_len, 2);
    idle(1);
    idle(0);
    header(18);
    chk("ovf_sticky", bus.ovf_err, 1);
    chk("trunc_len", bus.chunk_len, NB);
    header(2);
    idle(1); idle(0); idle(1); idle(0);
    for (int k = 0; k < 5; k++) begin
      step(1, k == 0, k == 4, 2'd0, 0);
      step(1, 1'($urandom), 1'($urandom), 2'd1, 0);
      step(1, 1'($urandom), 1'($urandom), 2'($urandom_range(1, 3)), 0);
    end
    idle(1); idle(0);
    header(2);
    step(1, 1, 0, 2'd0, 0);
    step(1, 0, 0, 2'd0, 0);
    do_reset();
    chk("reset_no_chunk", bus.chunk_valid, 0);
    idle(0);
    header(3);
    repeat (500) step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'd0,
                      $urandom_range(0, 2) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
